rv32_csr_file: RTL

//  Machine-mode CSR storage and trap sequencer for the RV32 core. Serves the

---
 rtl/rv32_csr_file.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/rv32_csr_file.sv
// Machine-mode CSR storage for the RV32 core: combinational CSR read, writeback
// commit, trap/mret sequencing, interrupt arbitration and the 64-bit counters.
`timescale 1ns/1ps
module rv32_csr_file #(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_illegal,
  input  logic        wr_en,
  input  logic [11:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_illegal,
  input  logic        retire,
  input  logic        trap_req,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_tval,
  input  logic        mret_req,
  input  logic        irq_ext,
  input  logic        irq_sw,
  input  logic        irq_timer,
  output logic        irq_take,
  output logic [31:0] irq_cause,
  output logic [31:0] trap_vector,
  output logic [31:0] epc
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CNTW = 64;
  localparam int unsigned CAW  = 12;

  localparam logic [CAW-1:0] CSR_MSTATUS   = 12'h300;
  localparam logic [CAW-1:0] CSR_MISA      = 12'h301;
  localparam logic [CAW-1:0] CSR_MIE       = 12'h304;
  localparam logic [CAW-1:0] CSR_MTVEC     = 12'h305;
  localparam logic [CAW-1:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [CAW-1:0] CSR_MEPC      = 12'h341;
  localparam logic [CAW-1:0] CSR_MCAUSE    = 12'h342;
  localparam logic [CAW-1:0] CSR_MTVAL     = 12'h343;
  localparam logic [CAW-1:0] CSR_MIP       = 12'h344;
  localparam logic [CAW-1:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [CAW-1:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [CAW-1:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [CAW-1:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [CAW-1:0] CSR_CYCLE     = 12'hC00;
  localparam logic [CAW-1:0] CSR_INSTRET   = 12'hC02;
  localparam logic [CAW-1:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [CAW-1:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [CAW-1:0] CSR_MHARTID   = 12'hF14;

  localparam logic [XLEN-1:0] MISA_VAL   = 32'h4000_0100;
  localparam logic [XLEN-1:0] MIE_MASK   = 32'h0000_0888;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] CAUSE_MEI  = 32'h8000_000B;
  localparam logic [XLEN-1:0] CAUSE_MSI  = 32'h8000_0003;
  localparam logic [XLEN-1:0] CAUSE_MTI  = 32'h8000_0007;

  logic            st_mie_q, st_mie_n;
  logic            st_mpie_q, st_mpie_n;
  logic [XLEN-1:0] mie_q, mie_n;
  logic [XLEN-1:0] mtvec_q, mtvec_n;
  logic [XLEN-1:0] mscratch_q, mscratch_n;
  logic [XLEN-1:0] mepc_q, mepc_n;
  logic [XLEN-1:0] mcause_q, mcause_n;
  logic [XLEN-1:0] mtval_q, mtval_n;
  logic [CNTW-1:0] mcycle_q, mcycle_n;
  logic [CNTW-1:0] minstret_q, minstret_n;

  logic [XLEN-1:0] mstatus_rd;
  logic [XLEN-1:0] mip_rd;
  logic [XLEN-1:0] irq_pend;
  logic            wr_commit;

  function automatic logic csr_implemented(input logic [CAW-1:0] a);
    case (a)
      CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
      CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH,
      CSR_MINSTRETH, CSR_CYCLE, CSR_INSTRET, CSR_CYCLEH, CSR_INSTRETH,
      CSR_MHARTID: return 1'b1;
      default:     return 1'b0;
    endcase
  endfunction

  assign mstatus_rd = {19'd0, 2'b11, 3'd0, st_mpie_q, 3'd0, st_mie_q, 3'd0};
  assign mip_rd     = {20'd0, irq_ext, 3'd0, irq_timer, 3'd0, irq_sw, 3'd0};

  // Combinational read port; no bypass of a same-cycle write.
  always_comb begin
    rd_data    = '0;
    rd_illegal = 1'b0;
    case (rd_addr)
      CSR_MSTATUS:               rd_data = mstatus_rd;
      CSR_MISA:                  rd_data = MISA_VAL;
      CSR_MIE:                   rd_data = mie_q;
      CSR_MTVEC:                 rd_data = mtvec_q;
      CSR_MSCRATCH:              rd_data = mscratch_q;
      CSR_MEPC:                  rd_data = mepc_q;
      CSR_MCAUSE:                rd_data = mcause_q;
      CSR_MTVAL:                 rd_data = mtval_q;
      CSR_MIP:                   rd_data = mip_rd;
      CSR_MCYCLE, CSR_CYCLE:     rd_data = mcycle_q[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:   rd_data = mcycle_q[63:32];
      CSR_MINSTRET, CSR_INSTRET: rd_data = minstret_q[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rd_data = minstret_q[63:32];
      CSR_MHARTID:               rd_data = HART_ID;
      default:                   rd_illegal = 1'b1;
    endcase
  end

  assign wr_illegal = wr_en & (~csr_implemented(wr_addr) | (wr_addr[11:10] == 2'b11));
  assign wr_commit  = wr_en & ~wr_illegal;

  // Next-state: trap beats mret beats CSR write; counters tick unless written.
  always_comb begin
    st_mie_n   = st_mie_q;
    st_mpie_n  = st_mpie_q;
    mie_n      = mie_q;
    mtvec_n    = mtvec_q;
    mscratch_n = mscratch_q;
    mepc_n     = mepc_q;
    mcause_n   = mcause_q;
    mtval_n    = mtval_q;
    mcycle_n   = mcycle_q + CNTW'(1);
    minstret_n = retire ? minstret_q + CNTW'(1) : minstret_q;

    if (trap_req) begin
      mepc_n    = trap_pc & ALIGN_MASK;
      mcause_n  = trap_cause;
      mtval_n   = trap_tval;
      st_mpie_n = st_mie_q;
      st_mie_n  = 1'b0;
    end else if (mret_req) begin
      st_mie_n  = st_mpie_q;
      st_mpie_n = 1'b1;
    end else if (wr_commit) begin
      case (wr_addr)
        CSR_MSTATUS: begin
          st_mie_n  = wr_data[3];
          st_mpie_n = wr_data[7];
        end
        CSR_MIE:       mie_n      = wr_data & MIE_MASK;
        CSR_MTVEC:     mtvec_n    = wr_data & ALIGN_MASK;
        CSR_MSCRATCH:  mscratch_n = wr_data;
        CSR_MEPC:      mepc_n     = wr_data & ALIGN_MASK;
        CSR_MCAUSE:    mcause_n   = wr_data;
        CSR_MTVAL:     mtval_n    = wr_data;
        CSR_MCYCLE:    mcycle_n   = {mcycle_q[63:32], wr_data};
        CSR_MCYCLEH:   mcycle_n   = {wr_data, mcycle_q[31:0]};
        CSR_MINSTRET:  minstret_n = {minstret_q[63:32], wr_data};
        CSR_MINSTRETH: minstret_n = {wr_data, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= RESET_MTVEC & ALIGN_MASK;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      st_mie_q   <= st_mie_n;
      st_mpie_q  <= st_mpie_n;
      mie_q      <= mie_n;
      mtvec_q    <= mtvec_n;
      mscratch_q <= mscratch_n;
      mepc_q     <= mepc_n;
      mcause_q   <= mcause_n;
      mtval_q    <= mtval_n;
      mcycle_q   <= mcycle_n;
      minstret_q <= minstret_n;
    end
  end

  // Interrupt arbitration: external > software > timer.
  assign irq_pend = mip_rd & mie_q;
  assign irq_take = ~reset & st_mie_q & (|irq_pend);

  always_comb begin
    irq_cause = '0;
    if (irq_take) begin
      if (irq_pend[11])     irq_cause = CAUSE_MEI;
      else if (irq_pend[3]) irq_cause = CAUSE_MSI;
      else                  irq_cause = CAUSE_MTI;
    end
  end

  assign trap_vector = mtvec_q;
  assign epc         = mepc_q;

endmodule
